// File: rtl/program_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : program_memory_ctrl
// Purpose  : Sequencer and arbiter in front of the TinyBF program memory.
//            Shares the memory's single read port and single write port
//            between the CPU fetch path and a byte-wide host interface.
//            The host interface supports loading the program and reading
//            the whole memory back. The controller holds off all traffic
//            until the memory's self-initialisation window has elapsed.
// Ports    : clk_i/rst_i          clock, async active-high reset
//            load_req_i           host request to enter/stay in LOAD
//            rb_req_i             host request for a full readback
//            hv_valid_i/hv_data_i host write byte; hv_ready_o accepts it
//            rb_valid_o/rb_data_o readback byte; rb_ready_i accepts it
//            cpu_ren_i/cpu_addr_i CPU fetch request
//            cpu_rdata_o/cpu_rvalid_o fetched instruction (1-cycle latency)
//            cpu_stall_o          CPU must hold its fetch request
//            pm_*                 program memory read/write ports
//            init_done_o          initialisation window elapsed
//            busy_o               controller not in RUN
//            load_count_o         bytes written in current/last LOAD session
// Revision : 1.0 - initial release
// ============================================================================
module program_memory_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic              rb_req_i,
  input  logic              hv_valid_i,
  input  logic [DATA_W-1:0] hv_data_i,
  output logic              hv_ready_o,
  output logic              rb_valid_o,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              rb_ready_i,
  input  logic              cpu_ren_i,
  input  logic [AW-1:0]     cpu_addr_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_rvalid_o,
  output logic              cpu_stall_o,
  output logic              pm_wen_o,
  output logic [AW-1:0]     pm_waddr_o,
  output logic [DATA_W-1:0] pm_wdata_o,
  output logic              pm_ren_o,
  output logic [AW-1:0]     pm_raddr_o,
  input  logic [DATA_W-1:0] pm_rdata_i,
  output logic              init_done_o,
  output logic              busy_o,
  output logic [AW:0]       load_count_o
);

  // Init counter must be able to hold the value DEPTH itself.
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_RUN        = 3'd1,
    S_LOAD       = 3'd2,
    S_RB_ISSUE   = 3'd3,
    S_RB_WAIT    = 3'd4,
    S_RB_PRESENT = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   init_cnt;
  logic [AW-1:0]   ptr;       // shared by load writes and readback reads
  logic            ptr_full;  // set once the last address has been written
  logic            wr_fire;

  // --------------------------------------------------------------------------
  // Combinational port muxing. Reads and writes are mutually exclusive by
  // state: writes only in LOAD, reads only in RUN and RB_ISSUE.
  // --------------------------------------------------------------------------
  assign hv_ready_o  = (state == S_LOAD) && !ptr_full;
  assign wr_fire     = hv_valid_i && hv_ready_o;

  assign pm_wen_o    = wr_fire;
  assign pm_waddr_o  = ptr;
  assign pm_wdata_o  = hv_data_i;

  assign pm_ren_o    = (state == S_RUN) ? cpu_ren_i : (state == S_RB_ISSUE);
  assign pm_raddr_o  = (state == S_RUN) ? cpu_addr_i : ptr;

  assign cpu_rdata_o = pm_rdata_i;
  assign cpu_stall_o = (state != S_RUN);
  assign busy_o      = (state != S_RUN);

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_INIT;
      init_cnt     <= '0;
      ptr          <= '0;
      ptr_full     <= 1'b0;
      load_count_o <= '0;
      rb_valid_o   <= 1'b0;
      rb_data_o    <= '0;
      cpu_rvalid_o <= 1'b0;
      init_done_o  <= 1'b0;
    end else begin
      // A fetch granted in the last RUN cycle still returns its data in the
      // first cycle of LOAD/readback.
      cpu_rvalid_o <= (state == S_RUN) && cpu_ren_i;

      case (state)
        S_INIT: begin
          if (init_cnt == CW'(DEPTH)) begin
            state       <= S_RUN;
            init_done_o <= 1'b1;
          end else begin
            init_cnt <= init_cnt + CW'(1);
          end
        end

        S_RUN: begin
          if (load_req_i) begin
            state        <= S_LOAD;
            ptr          <= '0;
            ptr_full     <= 1'b0;
            load_count_o <= '0;
          end else if (rb_req_i) begin
            state <= S_RB_ISSUE;
            ptr   <= '0;
          end
        end

        S_LOAD: begin
          if (wr_fire) begin
            load_count_o <= load_count_o + (AW+1)'(1);
            // Saturate at the last address instead of wrapping so address 0
            // can never be overwritten within one session.
            if (ptr == LAST_ADDR) begin
              ptr_full <= 1'b1;
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
          if (!load_req_i) begin
            state <= S_RUN;
          end
        end

        S_RB_ISSUE: begin
          state <= S_RB_WAIT;
        end

        S_RB_WAIT: begin
          rb_data_o  <= pm_rdata_i;
          rb_valid_o <= 1'b1;
          state      <= S_RB_PRESENT;
        end

        S_RB_PRESENT: begin
          if (rb_ready_i) begin
            rb_valid_o <= 1'b0;
            if (ptr == LAST_ADDR) begin
              state <= S_RUN;
            end else begin
              ptr   <= ptr + AW'(1);
              state <= S_RB_ISSUE;
            end
          end
        end

        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_memory_ctrl
// Purpose  : Self-checking bench for program_memory_ctrl. Contains a simple
//            1-cycle-latency RAM, a behavioural reference of the controller
//            and directed plus randomized host/CPU stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_memory_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_req = 1'b0;
  logic              rb_req = 1'b0;
  logic              hv_valid = 1'b0;
  logic [DATA_W-1:0] hv_data = '0;
  logic              hv_ready;
  logic              rb_valid;
  logic [DATA_W-1:0] rb_data;
  logic              rb_ready = 1'b0;
  logic              cpu_ren = 1'b0;
  logic [AW-1:0]     cpu_addr = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_stall;
  logic              pm_wen;
  logic [AW-1:0]     pm_waddr;
  logic [DATA_W-1:0] pm_wdata;
  logic              pm_ren;
  logic [AW-1:0]     pm_raddr;
  logic [DATA_W-1:0] pm_rdata;
  logic              init_done;
  logic              busy;
  logic [AW:0]       load_count;

  always #5 clk = ~clk;

  program_memory_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .load_req_i(load_req), .rb_req_i(rb_req),
    .hv_valid_i(hv_valid), .hv_data_i(hv_data), .hv_ready_o(hv_ready),
    .rb_valid_o(rb_valid), .rb_data_o(rb_data), .rb_ready_i(rb_ready),
    .cpu_ren_i(cpu_ren), .cpu_addr_i(cpu_addr), .cpu_rdata_o(cpu_rdata),
    .cpu_rvalid_o(cpu_rvalid), .cpu_stall_o(cpu_stall),
    .pm_wen_o(pm_wen), .pm_waddr_o(pm_waddr), .pm_wdata_o(pm_wdata),
    .pm_ren_o(pm_ren), .pm_raddr_o(pm_raddr), .pm_rdata_i(pm_rdata),
    .init_done_o(init_done), .busy_o(busy), .load_count_o(load_count)
  );

  // Program memory: 1-cycle read latency, contents cleared by reset.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      pm_rdata <= '0;
    end else begin
      if (pm_wen) ram[pm_waddr] <= pm_wdata;
      if (pm_ren) pm_rdata <= ram[pm_raddr];
    end
  end

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: who owns the memory, where the next load byte goes,
  // which byte readback is on and how long until it appears, plus the
  // expected memory image.
  // --------------------------------------------------------------------------
  localparam int M_INIT = 0, M_RUN = 1, M_LOAD = 2, M_RB = 3;
  int                m_mode;
  int                m_init;     // cycles spent initialising
  int                m_wptr;     // next load address, DEPTH when full
  int                m_cnt;      // bytes loaded this session
  int                m_rbi;      // readback byte index
  int                m_rbd;      // cycles until that byte is presented
  bit                m_pf;       // fetch granted last cycle
  int                m_pa;       // its address
  logic [DATA_W-1:0] gm [DEPTH];

  task automatic model_reset();
    m_mode = M_INIT; m_init = 0; m_wptr = 0; m_cnt = 0;
    m_rbi = 0; m_rbd = 0; m_pf = 1'b0; m_pa = 0;
    for (int i = 0; i < DEPTH; i++) gm[i] = '0;
  endtask

  task automatic model_step();
    bit e_ready, e_wen, e_ren_cpu, e_ren_rb, fetch;
    e_ready   = (m_mode == M_LOAD) && (m_wptr < DEPTH);
    e_wen     = e_ready && hv_valid;
    e_ren_cpu = (m_mode == M_RUN) && cpu_ren;
    e_ren_rb  = (m_mode == M_RB) && (m_rbd == 2);

    chk("init_done", init_done, m_mode != M_INIT);
    chk("busy", busy, m_mode != M_RUN);
    chk("cpu_stall", cpu_stall, m_mode != M_RUN);
    chk("hv_ready", hv_ready, e_ready);
    chk("pm_wen", pm_wen, e_wen);
    if (e_wen) begin
      chk("pm_waddr", pm_waddr, m_wptr);
      chk("pm_wdata", pm_wdata, hv_data);
    end
    chk("pm_ren", pm_ren, e_ren_cpu || e_ren_rb);
    if (e_ren_cpu) chk("pm_raddr_cpu", pm_raddr, cpu_addr);
    if (e_ren_rb)  chk("pm_raddr_rb", pm_raddr, m_rbi);
    chk("cpu_rvalid", cpu_rvalid, m_pf);
    if (m_pf) chk("cpu_rdata", cpu_rdata, gm[m_pa]);
    chk("rb_valid", rb_valid, (m_mode == M_RB) && (m_rbd == 0));
    if ((m_mode == M_RB) && (m_rbd == 0)) chk("rb_data", rb_data, gm[m_rbi]);
    chk("load_count", load_count, m_cnt);

    if (rst) return;

    fetch = e_ren_cpu;
    case (m_mode)
      M_INIT: if (m_init == DEPTH) m_mode = M_RUN; else m_init++;
      M_RUN: begin
        if (load_req) begin
          m_mode = M_LOAD; m_wptr = 0; m_cnt = 0;
        end else if (rb_req) begin
          m_mode = M_RB; m_rbi = 0; m_rbd = 2;
        end
      end
      M_LOAD: begin
        if (e_wen) begin
          gm[m_wptr] = hv_data; m_wptr++; m_cnt++;
        end
        if (!load_req) m_mode = M_RUN;
      end
      default: begin
        if (m_rbd > 0) m_rbd--;
        else if (rb_ready) begin
          if (m_rbi == DEPTH - 1) m_mode = M_RUN;
          else begin m_rbi++; m_rbd = 2; end
        end
      end
    endcase
    m_pf = fetch;
    m_pa = int'(cpu_addr);
  endtask

  // Compare process: outputs are sampled on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      model_step();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus: inputs change 1 time unit after the rising edge.
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy) return;
      tick();
    end
    chk("wait_run_timeout", busy, 0);
  endtask

  initial begin
    int low, idx, guard, offered, writes, nb, g;
    logic [DATA_W-1:0] q [3];
    q[0] = 8'h45; q[1] = 8'h80; q[2] = 8'h01;

    // Reset and initialisation window
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (init_done) break;
      low++;
    end
    chk("init_latency", low, 17);

    // Consecutive fetches, then random fetches
    tick(); cpu_ren = 1'b1; cpu_addr = 4'd0;
    tick(); cpu_addr = 4'd1;
    tick(); cpu_addr = 4'd2;
    for (int i = 0; i < 30; i++) begin
      tick(); cpu_ren = 1'($urandom % 2); cpu_addr = AW'($urandom);
    end

    // Short load with gaps; a fetch rides along with the request cycle
    tick(); cpu_ren = 1'b1; cpu_addr = 4'd5; load_req = 1'b1;
    tick(); cpu_ren = 1'b0;
    idx = 0; guard = 0;
    while (idx < 3 && guard < 100) begin
      hv_valid = 1'($urandom % 2); hv_data = q[idx];
      @(negedge clk);
      if (hv_valid && hv_ready) idx++;
      tick(); guard++;
    end
    if (guard >= 100) chk("load3_timeout", idx, 3);
    hv_valid = 1'b0; load_req = 1'b0;
    tick(); tick();
    chk("load3_count", load_count, 3);
    chk("load3_ram0", ram[0], 8'h45);
    chk("load3_ram1", ram[1], 8'h80);
    chk("load3_ram2", ram[2], 8'h01);
    chk("load3_run", busy, 0);

    for (int i = 0; i < 20; i++) begin
      cpu_ren = 1'($urandom % 2); cpu_addr = AW'($urandom); tick();
    end
    cpu_ren = 1'b0;

    // Overfull load: 20 bytes offered into 16 locations
    load_req = 1'b1; tick();
    offered = 0; writes = 0; guard = 0;
    while (offered < 20 && guard < 200) begin
      hv_valid = ($urandom % 4) != 0; hv_data = DATA_W'($urandom);
      @(negedge clk);
      if (hv_valid) offered++;
      if (pm_wen) writes++;
      tick(); guard++;
    end
    hv_valid = 1'b0; load_req = 1'b0;
    tick(); tick();
    chk("full_writes", writes, 16);
    chk("full_count", load_count, 16);

    // Readback with a slow host
    rb_req = 1'b1; tick(); rb_req = 1'b0;
    nb = 0;
    for (int b = 0; b < DEPTH; b++) begin
      g = 0;
      while (!rb_valid && g < 20) begin tick(); g++; end
      if (g >= 20) begin chk("rb_valid_timeout", rb_valid, 1); break; end
      repeat (4) tick();
      rb_ready = 1'b1; tick(); rb_ready = 1'b0;
      nb++;
    end
    chk("rb_bytes", nb, 16);
    tick();
    chk("rb_back_to_run", busy, 0);

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      if ($urandom % 8 == 0) load_req = ~load_req;
      rb_req   = ($urandom % 12) == 0;
      cpu_ren  = 1'($urandom % 2);
      cpu_addr = AW'($urandom);
      hv_valid = 1'($urandom % 2);
      hv_data  = DATA_W'($urandom);
      rb_ready = ($urandom % 3) == 0;
      tick();
    end
    load_req = 1'b0; rb_req = 1'b0; hv_valid = 1'b0; cpu_ren = 1'b0; rb_ready = 1'b1;
    wait_run(300);
    rb_ready = 1'b0;

    // Both requests together: load wins; then reset mid-load at write 7
    load_req = 1'b1; rb_req = 1'b1; tick();
    rb_req = 1'b0;
    chk("both_req_ready", hv_ready, 1);
    writes = 0; guard = 0;
    while (writes < 6 && guard < 50) begin
      hv_valid = 1'b1; hv_data = DATA_W'($urandom);
      @(negedge clk);
      if (pm_wen) writes++;
      tick(); guard++;
    end
    chk("pre_rst_writes", writes, 6);
    hv_valid = 1'b1; hv_data = 8'hA5;
    #1 rst = 1'b1;
    #1;
    chk("rst_wen_drop", pm_wen, 0);
    chk("rst_count", load_count, 0);
    chk("rst_init_done", init_done, 0);
    tick();
    rst = 1'b0; hv_valid = 1'b0; load_req = 1'b0;
    wait_run(40);
    for (int i = 0; i < 10; i++) begin
      cpu_ren = 1'b1; cpu_addr = AW'(i); tick();
    end
    cpu_ren = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
